// File: rtl/fetch_pkg.sv
// Shared constants, FSM encoding and address helper for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'h0000_0004;

    typedef enum logic [1:0] {
        FETCH       = 2'd0,
        STALL_EMPTY = 2'd1,
        STALL_FULL  = 2'd2
    } fetch_state_e;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return addr & {{(XLEN-2){1'b1}}, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and the memory (slave).
interface fetch_if;
    import fetch_pkg::*;

    logic [XLEN-1:0] InstrAddr;
    logic            InstrRd;
    logic [XLEN-1:0] InstrData;

    modport master (output InstrAddr, output InstrRd, input InstrData);
    modport slave  (input InstrAddr, input InstrRd, output InstrData);
endinterface

// File: rtl/fetch_checker.sv
// Invariants of the fetch stage: the skid can never be asked to hold two words.
module fetch_checker
    import fetch_pkg::*;
(
    input logic            clk,
    input logic            rst,
    input logic            skid_full,
    input logic            skid_load,
    input logic            pend,
    input logic [XLEN-1:0] instr_addr
);
    // A word returning while the skid is occupied would have nowhere to go.
    a_no_skid_overflow: assert property (@(posedge clk) disable iff (rst) !(skid_full && pend));
    a_no_skid_reload:   assert property (@(posedge clk) disable iff (rst) !(skid_full && skid_load));
    a_word_aligned:     assert property (@(posedge clk) disable iff (rst) instr_addr[1:0] == 2'b00);
endmodule

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for a fetched word that returns while decode is stalled.
module fetch_skid_buffer
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            drain,
    input  logic            clear,
    input  logic [XLEN-1:0] din_data,
    input  logic [XLEN-1:0] din_pc,
    output logic [XLEN-1:0] data,
    output logic [XLEN-1:0] pc,
    output logic            full
);
    logic [XLEN-1:0] data_r;
    logic [XLEN-1:0] pc_r;
    logic            full_r;

    // Entry storage; clear (redirect) outranks a simultaneous load or drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r <= 32'h0000_0000;
            pc_r   <= 32'h0000_0000;
            full_r <= 1'b0;
        end else if (clear) begin
            full_r <= 1'b0;
        end else if (load) begin
            data_r <= din_data;
            pc_r   <= din_pc;
            full_r <= 1'b1;
        end else if (drain) begin
            full_r <= 1'b0;
        end else begin
            full_r <= full_r;
        end
    end

    assign data = data_r;
    assign pc   = pc_r;
    assign full = full_r;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC sequencing, one outstanding memory read, and the IF/ID
// register backed by a one-entry skid so a stall never drops a returning word.
module fetch_stage
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    fetch_if.master         imem,
    input  logic            Stall,
    input  logic            BranchTaken,
    input  logic [XLEN-1:0] BranchTarget,
    output logic [XLEN-1:0] Instruccion,
    output logic [XLEN-1:0] PCout,
    output logic            Valid
);
    fetch_state_e    state_r;
    fetch_state_e    state_nx_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pend_pc_r;
    logic            pend_r;
    logic [XLEN-1:0] instr_r;
    logic [XLEN-1:0] pcout_r;
    logic            valid_r;
    logic            instr_rd_s;
    logic            ifid_mem_s;
    logic            ifid_skid_s;
    logic            ifid_bubble_s;
    logic            skid_load_s;
    logic            skid_drain_s;
    logic            skid_clear_s;
    logic            skid_full_s;
    logic [XLEN-1:0] skid_data_s;
    logic [XLEN-1:0] skid_pc_s;

    // A fetch goes out whenever decode is not holding and no redirect is pending.
    assign instr_rd_s     = ~Stall & ~BranchTaken & ~rst;
    assign imem.InstrRd   = instr_rd_s;
    assign imem.InstrAddr = pc_r;
    assign Instruccion    = instr_r;
    assign PCout          = pcout_r;
    assign Valid          = valid_r;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic; a redirect always returns to FETCH.
    always_comb begin
        state_nx_s = state_r;
        if (BranchTaken) begin
            state_nx_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    if (Stall) begin
                        state_nx_s = pend_r ? STALL_FULL : STALL_EMPTY;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end
                STALL_EMPTY, STALL_FULL: begin
                    if (Stall) begin
                        state_nx_s = state_r;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end
                default: state_nx_s = FETCH;
            endcase
        end
    end

    // FSM outputs: where IF/ID loads from and what the skid does this cycle.
    always_comb begin
        ifid_mem_s    = 1'b0;
        ifid_skid_s   = 1'b0;
        ifid_bubble_s = 1'b0;
        skid_load_s   = 1'b0;
        skid_drain_s  = 1'b0;
        skid_clear_s  = 1'b0;
        if (BranchTaken) begin
            ifid_bubble_s = 1'b1;
            skid_clear_s  = 1'b1;
        end else begin
            case (state_r)
                FETCH: begin
                    if (Stall) begin
                        skid_load_s = pend_r;
                    end else begin
                        ifid_mem_s    = pend_r;
                        ifid_bubble_s = ~pend_r;
                    end
                end
                STALL_EMPTY: begin
                    if (!Stall) begin
                        ifid_mem_s    = pend_r;
                        ifid_bubble_s = ~pend_r;
                    end else begin
                        ifid_mem_s = 1'b0;
                    end
                end
                STALL_FULL: begin
                    if (!Stall) begin
                        ifid_skid_s  = 1'b1;
                        skid_drain_s = 1'b1;
                    end else begin
                        ifid_skid_s = 1'b0;
                    end
                end
                default: begin
                    ifid_bubble_s = 1'b1;
                    skid_clear_s  = 1'b1;
                end
            endcase
        end
    end

    // PC and the single in-flight fetch tracker.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_r      <= RESET_PC;
            pend_r    <= 1'b0;
            pend_pc_r <= RESET_PC;
        end else if (BranchTaken) begin
            pc_r   <= align_word(BranchTarget);
            pend_r <= 1'b0;
        end else if (instr_rd_s) begin
            pc_r      <= pc_r + PC_STEP;
            pend_r    <= 1'b1;
            pend_pc_r <= pc_r;
        end else begin
            pend_r <= 1'b0;
        end
    end

    // IF/ID register; a bubble only drops Valid and leaves the payload alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_r <= 32'h0000_0000;
            pcout_r <= 32'h0000_0000;
            valid_r <= 1'b0;
        end else if (ifid_mem_s) begin
            instr_r <= imem.InstrData;
            pcout_r <= pend_pc_r;
            valid_r <= 1'b1;
        end else if (ifid_skid_s) begin
            instr_r <= skid_data_s;
            pcout_r <= skid_pc_s;
            valid_r <= 1'b1;
        end else if (ifid_bubble_s) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= valid_r;
        end
    end

    fetch_skid_buffer u_skid (
        .clk      (clk),
        .rst      (rst),
        .load     (skid_load_s),
        .drain    (skid_drain_s),
        .clear    (skid_clear_s),
        .din_data (imem.InstrData),
        .din_pc   (pend_pc_r),
        .data     (skid_data_s),
        .pc       (skid_pc_s),
        .full     (skid_full_s)
    );

    fetch_checker u_checker (
        .clk        (clk),
        .rst        (rst),
        .skid_full  (skid_full_s),
        .skid_load  (skid_load_s),
        .pend       (pend_r),
        .instr_addr (pc_r)
    );
endmodule

// File: tb/tb_fetch_stage.sv
// Randomized scoreboard bench for fetch_stage against a fetch-stream reference model.
module tb_fetch_stage;
    import fetch_pkg::*;

    typedef struct {
        logic        rst;
        logic        rd;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] Instruccion;
    logic [31:0] PCout;
    logic        Valid;

    fetch_if bus ();

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (bus),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .Instruccion  (Instruccion),
        .PCout        (PCout),
        .Valid        (Valid)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    exp_t        sb[$];

    // Reference model: addresses fetched but not yet delivered, next fetch address, IF/ID view.
    logic [31:0] m_inflight[$];
    logic [31:0] m_pc    = 32'h0;
    logic        m_valid = 1'b0;
    logic [31:0] m_pcout = 32'h0;
    logic [31:0] m_instr = 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h080402F3;
        return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    // Memory: word is valid the cycle after a read; otherwise the bus carries junk.
    always @(posedge clk) begin
        if (bus.InstrRd) bus.InstrData <= mem_word(bus.InstrAddr);
        else             bus.InstrData <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Apply one cycle of inputs and push what the outputs must look like in that cycle.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] t);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; Stall = s; BranchTaken = b; BranchTarget = t;
        e.rst = r;
        if (r) begin
            m_inflight.delete();
            m_pc = 32'h0; m_valid = 1'b0; m_pcout = 32'h0; m_instr = 32'h0;
            e.rd = 1'b0; e.addr = 32'h0; e.valid = 1'b0; e.pc = 32'h0; e.instr = 32'h0;
        end else begin
            e.rd = !s && !b; e.addr = m_pc;
            e.valid = m_valid; e.pc = m_pcout; e.instr = m_instr;
            if (b) begin
                m_inflight.delete();
                m_pc    = t & 32'hFFFF_FFFC;
                m_valid = 1'b0;
            end else if (!s) begin
                if (m_inflight.size() > 0) begin
                    m_pcout = m_inflight.pop_front();
                    m_instr = mem_word(m_pcout);
                    m_valid = 1'b1;
                end else begin
                    m_valid = 1'b0;
                end
                m_inflight.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
        sb.push_back(e);
    endtask

    // Monitor: compare what the DUT presents mid-cycle with the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("InstrRd", {31'b0, bus.InstrRd}, {31'b0, e.rd});
            chk("InstrAddr", bus.InstrAddr, e.addr);
            chk("Valid", {31'b0, Valid}, {31'b0, e.valid});
            if (e.valid || e.rst) begin
                chk("PCout", PCout, e.pc);
                chk("Instruccion", Instruccion, e.instr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; BranchTarget = 32'h0;
        bus.InstrData = 32'h0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        // Free run from address 0, then a three-cycle stall while PCout=4.
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect to an unaligned target.
        step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Redirect together with a stall while the skid holds a word.
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        repeat (3) step(1'b0, 1'b0, 1'b0, 32'h0);
        // PC wrap at the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Reset while stalled with a full skid.
        repeat (2) step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic        s;
            logic        b;
            logic [31:0] t;
            r = ($urandom_range(0, 99) < 2);
            s = ($urandom_range(0, 99) < 35);
            b = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 2))
                0:       t = $urandom;
                1:       t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                default: t = $urandom & 32'h0000_00FF;
            endcase
            step(r, s, b, t);
        end
        @(negedge clk);
        @(negedge clk);
        chk("sb_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
